// File: rtl/iccm_loader_pkg.sv
// Shared types and constants for the ICCM boot loader.
// Holds the FSM state encoding, header/word byte counts and the word-count type.
// No logic; imported by iccm_loader and byte_packer.
package iccm_loader_pkg;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // Word count carried in the stream header.
  typedef logic [HDR_BYTES*8-1:0] wcount_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_LO,
    S_HDR_HI,
    S_COLLECT,
    S_WRITE,
    S_RD_REQ,
    S_RD_WAIT,
    S_DONE
  } state_e;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler: first byte lands in [7:0].
// word_vld_o is combinational with the final byte's strobe, so the word is usable that same cycle.
// No backpressure: every byte_vld_i is consumed; clr_i discards a partial word.
module byte_packer
  import iccm_loader_pkg::*;
(
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  clr_i,
  input  logic                                  byte_vld_i,
  input  logic [7:0]                            byte_i,
  output logic                                  word_vld_o,
  output logic [BYTES_PER_WORD*8-1:0]           word_o,
  output logic [$clog2(BYTES_PER_WORD)-1:0]     idx_o
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);
  localparam int SH_W  = 8 * (BYTES_PER_WORD - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SH_W-1:0]  sh_q,  sh_d;

  // New bytes enter at the top and slide down, so the oldest ends up in the low lane.
  always_comb begin
    idx_d = idx_q;
    sh_d  = sh_q;
    if (clr_i) begin
      idx_d = '0;
      sh_d  = '0;
    end else if (byte_vld_i) begin
      sh_d  = {byte_i, sh_q[SH_W-1:8]};
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Shift register and byte index state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q <= '0;
      sh_q  <= '0;
    end else begin
      idx_q <= idx_d;
      sh_q  <= sh_d;
    end
  end

  assign word_vld_o = byte_vld_i && !clr_i && (idx_q == LAST_IDX);
  assign word_o     = {byte_i, sh_q};
  assign idx_o      = idx_q;

endmodule

// File: rtl/iccm_loader.sv
// Boot loader: UART byte stream (16-bit count + LE words) -> full-word ICCM writes; holds core in reset.
// Write request issues the cycle after a word's 4th byte; optional ICCM_READBACK_EN adds a read-verify.
// No backpressure on the byte stream; readback buffers one byte, a second early byte flags an error.
module iccm_loader
  import iccm_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  rx_valid_i,
  input  logic [7:0]            rx_byte_i,
  output logic                  req_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [31:0]           wdata_o,
  output logic [3:0]            wmask_o,
  input  logic [31:0]           rdata_i,
  input  logic                  rvalid_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  core_rst_o
);

  localparam logic [ADDR_WIDTH:0]   BASE_W   = (ADDR_WIDTH + 1)'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [31:0]           CAPACITY = (32'd1 << ADDR_WIDTH) - 32'(BASE_ADDR);

  state_e                state_q, state_d;
  logic [7:0]            cnt_lo_q, cnt_lo_d;
  wcount_t               rem_q, rem_d;
  logic [ADDR_WIDTH:0]   waddr_q, waddr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  core_rst_q, core_rst_d;

  logic        pk_clr, pk_vld, pk_word_vld;
  logic [7:0]  pk_dat;
  logic [31:0] pk_word;
  logic [1:0]  pk_idx;
  logic        accept, launch, fin, fin_err;
  wcount_t     hdr_count;

`ifdef ICCM_READBACK_EN
  logic       hold_vld_q, hold_vld_d;
  logic [7:0] hold_dat_q, hold_dat_d;
  logic       unused_ok;
  assign unused_ok = ^pk_idx;
`else
  logic       unused_ok;
  assign unused_ok = ^{rdata_i, rvalid_i, pk_idx};
`endif

  byte_packer u_packer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (pk_clr),
    .byte_vld_i (pk_vld),
    .byte_i     (pk_dat),
    .word_vld_o (pk_word_vld),
    .word_o     (pk_word),
    .idx_o      (pk_idx)
  );

  // Next-state, byte routing and status flag updates.
  always_comb begin
    state_d    = state_q;
    cnt_lo_d   = cnt_lo_q;
    rem_d      = rem_q;
    waddr_d    = waddr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    core_rst_d = core_rst_q;
    pk_clr     = 1'b0;
    pk_dat     = rx_byte_i;
    hdr_count  = {rx_byte_i, cnt_lo_q};
    launch     = 1'b0;
    fin        = 1'b0;
    fin_err    = 1'b0;
    // WRITE still accepts a byte so a back-to-back stream loses nothing.
    accept     = (state_q == S_COLLECT) || (state_q == S_WRITE);

`ifdef ICCM_READBACK_EN
    hold_vld_d = hold_vld_q;
    hold_dat_d = hold_dat_q;
    // A held byte drains first; a byte arriving alongside takes its place.
    pk_vld = accept && (hold_vld_q || rx_valid_i);
    if (hold_vld_q) pk_dat = hold_dat_q;
    if (accept) begin
      hold_vld_d = hold_vld_q && rx_valid_i;
      if (hold_vld_q && rx_valid_i) hold_dat_d = rx_byte_i;
    end
`else
    pk_vld = accept && rx_valid_i;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) launch = 1'b1;
      end
      S_HDR_LO: begin
        if (rx_valid_i) begin
          cnt_lo_d = rx_byte_i;
          state_d  = S_HDR_HI;
        end
      end
      S_HDR_HI: begin
        if (rx_valid_i) begin
          rem_d = hdr_count;
          if (hdr_count == '0) begin
            fin = 1'b1;
          end else if ({16'd0, hdr_count} > CAPACITY) begin
            fin     = 1'b1;
            fin_err = 1'b1;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (pk_word_vld) begin
          wdata_d = pk_word;
          addr_d  = waddr_q[ADDR_WIDTH-1:0];
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        waddr_d = waddr_q + (ADDR_WIDTH + 1)'(1);
        rem_d   = rem_q - wcount_t'(1);
`ifdef ICCM_READBACK_EN
        state_d = S_RD_REQ;
`else
        if (rem_q > wcount_t'(1)) state_d = S_COLLECT;
        else                      fin     = 1'b1;
`endif
      end
`ifdef ICCM_READBACK_EN
      S_RD_REQ: begin
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // rem_q was already decremented in WRITE.
        if (rvalid_i) begin
          if (rdata_i != wdata_q) begin
            fin     = 1'b1;
            fin_err = 1'b1;
          end else if (rem_q != '0) begin
            state_d = S_COLLECT;
          end else begin
            fin = 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

`ifdef ICCM_READBACK_EN
    if (((state_q == S_RD_REQ) || (state_q == S_RD_WAIT)) && rx_valid_i) begin
      if (hold_vld_q) begin
        fin     = 1'b1;
        fin_err = 1'b1;
      end else begin
        hold_vld_d = 1'b1;
        hold_dat_d = rx_byte_i;
      end
    end
`endif

    if (fin) begin
      state_d    = S_DONE;
      busy_d     = 1'b0;
      done_d     = 1'b1;
      err_d      = fin_err;
      core_rst_d = fin_err;
    end

    if (launch) begin
      state_d    = S_HDR_LO;
      busy_d     = 1'b1;
      done_d     = 1'b0;
      err_d      = 1'b0;
      core_rst_d = 1'b1;
      waddr_d    = BASE_W;
      pk_clr     = 1'b1;
`ifdef ICCM_READBACK_EN
      hold_vld_d = 1'b0;
`endif
    end
  end

  // State and output registers; reset aborts any load in progress.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_lo_q   <= '0;
      rem_q      <= '0;
      waddr_q    <= BASE_W;
      addr_q     <= BASE_A;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      core_rst_q <= 1'b1;
`ifdef ICCM_READBACK_EN
      hold_vld_q <= 1'b0;
      hold_dat_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_lo_q   <= cnt_lo_d;
      rem_q      <= rem_d;
      waddr_q    <= waddr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      core_rst_q <= core_rst_d;
`ifdef ICCM_READBACK_EN
      hold_vld_q <= hold_vld_d;
      hold_dat_q <= hold_dat_d;
`endif
    end
  end

`ifdef ICCM_READBACK_EN
  assign req_o = (state_q == S_WRITE) || (state_q == S_RD_REQ);
`else
  assign req_o = (state_q == S_WRITE);
`endif
  assign we_o       = (state_q == S_WRITE);
  assign wmask_o    = (state_q == S_WRITE) ? 4'hF : 4'h0;
  assign addr_o     = addr_q;
  assign wdata_o    = wdata_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign core_rst_o = core_rst_q;

endmodule

// File: tb/tb_iccm_loader.sv
// Directed bench for iccm_loader: vector table of byte streams plus hand sequences.
// Covers reset, header edge cases, latency, async reset mid-load and the 4096-word limit.
// ICCM_READBACK_EN builds add a corrupting-memory check.
module tb_iccm_loader;

`ifdef ICCM_READBACK_EN
  localparam int   MIN_GAP = 3;
  localparam logic RB      = 1'b1;
`else
  localparam int   MIN_GAP = 0;
  localparam logic RB      = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i, start_i, rx_valid_i;
  logic [7:0]  rx_byte_i;
  logic        req_o, we_o;
  logic [11:0] addr_o;
  logic [31:0] wdata_o;
  logic [3:0]  wmask_o;
  logic [31:0] rdata_i;
  logic        rvalid_i;
  logic        busy_o, done_o, err_o, core_rst_o;
  logic        corrupt;

  always #5 clk = ~clk;

  iccm_loader dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .rx_valid_i(rx_valid_i), .rx_byte_i(rx_byte_i),
    .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o), .wmask_o(wmask_o),
    .rdata_i(rdata_i), .rvalid_i(rvalid_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .core_rst_o(core_rst_o)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Write monitor, sampled on the falling edge.
  typedef struct { logic [11:0] a; logic [31:0] d; logic [3:0] m; } wr_t;
  wr_t  wq[$];
  int   dbl = 0;
  logic prev_wr = 1'b0;

  always @(negedge clk) begin
    if (req_o && we_o) begin
      wq.push_back(wr_t'{addr_o, wdata_o, wmask_o});
      if (prev_wr) dbl++;
    end
    prev_wr = req_o && we_o;
  end

  // Memory model answering reads one cycle after the request.
  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    if (rst_i) begin
      rvalid_i <= 1'b0;
      rdata_i  <= '0;
    end else begin
      rvalid_i <= req_o && !we_o;
      if (req_o && we_o) mem[addr_o] <= wdata_o;
      rdata_i <= mem[addr_o] ^ {31'b0, corrupt};
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    rx_valid_i = 1'b1;
    rx_byte_i  = b;
    @(posedge clk); #1;
    rx_valid_i = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int lim, input string nm);
    int k = 0;
    while (!(done_o === 1'b1 && busy_o === 1'b0) && k < lim) begin
      @(posedge clk); #1;
      k++;
    end
    chk({nm, "_done_timeout"}, 32'(k < lim), 32'd1);
  endtask

  typedef struct {
    int   off; int n; int gap; int woff; int nw;
    logic done; logic err; logic crst;
  } vec_t;

  localparam int NV = 5;
  vec_t        vecs[NV];
  logic [7:0]  stream[$];
  logic [11:0] exp_a[$];
  logic [31:0] exp_d[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; start_i = 1'b0; rx_valid_i = 1'b0; rx_byte_i = 8'h00; corrupt = 1'b0;

    stream = '{8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12,
               8'h00, 8'h00,
               8'h01, 8'h10,
               8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
               8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
               8'h09, 8'h0A, 8'h0B, 8'h0C};
    exp_a  = '{12'h000, 12'h001, 12'h000, 12'h000, 12'h001, 12'h002};
    exp_d  = '{32'hDEADBEEF, 32'h12345678, 32'h44332211, 32'h04030201, 32'h08070605, 32'h0C0B0A09};
    vecs[0] = '{0,  10, 1, 0, 2, 1'b1, 1'b0, 1'b0};  // two words
    vecs[1] = '{10, 2,  1, 0, 0, 1'b1, 1'b0, 1'b0};  // empty image
    vecs[2] = '{12, 2,  1, 0, 0, 1'b1, 1'b1, 1'b1};  // 4097 words: too large
    vecs[3] = '{14, 6,  2, 2, 1, 1'b1, 1'b0, 1'b0};  // reload after error
    vecs[4] = '{20, 14, 0, 3, 3, 1'b1, 1'b0, 1'b0};  // back-to-back bytes

    repeat (3) @(posedge clk); #1;
    rst_i = 1'b0;
    repeat (10) @(posedge clk); #1;
    chk("rst_core_rst", core_rst_o, 1);
    chk("rst_req", req_o, 0);
    chk("rst_we", we_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_wmask", wmask_o, 0);

    for (int v = 0; v < NV; v++) begin
      int g;
      g = (vecs[v].gap > MIN_GAP) ? vecs[v].gap : MIN_GAP;
      wq.delete();
      pulse_start();
      chk($sformatf("v%0d_start_busy", v), busy_o, 1);
      chk($sformatf("v%0d_start_done", v), done_o, 0);
      chk($sformatf("v%0d_start_core_rst", v), core_rst_o, 1);
      for (int i = 0; i < vecs[v].n; i++) send(stream[vecs[v].off + i], g);
      wait_done(200, $sformatf("v%0d", v));
      chk($sformatf("v%0d_nwrites", v), 32'(wq.size()), 32'(vecs[v].nw));
      for (int j = 0; j < vecs[v].nw && j < wq.size(); j++) begin
        chk($sformatf("v%0d_w%0d_addr", v, j), wq[j].a, exp_a[vecs[v].woff + j]);
        chk($sformatf("v%0d_w%0d_data", v, j), wq[j].d, exp_d[vecs[v].woff + j]);
        chk($sformatf("v%0d_w%0d_mask", v, j), wq[j].m, 4'hF);
      end
      chk($sformatf("v%0d_done", v), done_o, vecs[v].done);
      chk($sformatf("v%0d_err", v), err_o, vecs[v].err);
      chk($sformatf("v%0d_core_rst", v), core_rst_o, vecs[v].crst);
    end

    // Latency, ignored start mid-load, held outputs, ignored bytes in DONE.
    wq.delete();
    pulse_start();
    send(8'h01, 1); send(8'h00, 1); send(8'h11, 1);
    pulse_start();
    send(8'h22, 1); send(8'h33, 1);
    rx_valid_i = 1'b1; rx_byte_i = 8'h44;
    @(posedge clk); #1;
    rx_valid_i = 1'b0;
    chk("lat_req", req_o, 1);
    chk("lat_we", we_o, 1);
    chk("lat_wmask", wmask_o, 4'hF);
    chk("lat_addr", addr_o, 0);
    chk("lat_wdata", wdata_o, 32'h44332211);
    @(posedge clk); #1;
    chk("after_req", req_o, RB);
    chk("after_we", we_o, 0);
    chk("after_wmask", wmask_o, 0);
    chk("after_wdata_hold", wdata_o, 32'h44332211);
    wait_done(50, "lat");
    chk("lat_nwrites", 32'(wq.size()), 1);
    chk("lat_core_rst", core_rst_o, 0);
    for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i), 1);
    chk("done_rx_ignored", 32'(wq.size()), 1);
    chk("done_sticky", done_o, 1);
    chk("done_not_busy", busy_o, 0);

    // Asynchronous reset after two payload bytes.
    wq.delete();
    pulse_start();
    send(8'h01, 1); send(8'h00, 1); send(8'hAA, 1); send(8'hBB, 1);
    rst_i = 1'b1;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_core_rst", core_rst_o, 1);
    chk("arst_req", req_o, 0);
    chk("arst_wdata", wdata_o, 0);
    chk("arst_addr", addr_o, 0);
    chk("arst_done", done_o, 0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    repeat (2) @(posedge clk); #1;
    send(8'hCC, 1); send(8'hDD, 1);
    chk("arst_no_partial_write", 32'(wq.size()), 0);
    chk("arst_idle_busy", busy_o, 0);
    pulse_start();
    send(8'h01, 1); send(8'h00, 1);
    send(8'h11, 1); send(8'h22, 1); send(8'h33, 1); send(8'h44, 1);
    wait_done(50, "arst_reload");
    chk("arst_reload_nwrites", 32'(wq.size()), 1);
    if (wq.size() > 0) begin
      chk("arst_reload_addr", wq[0].a, 0);
      chk("arst_reload_data", wq[0].d, 32'h44332211);
    end
    chk("arst_reload_core_rst", core_rst_o, 0);

    // Largest legal image: 4096 words fill the whole memory.
    begin
      int bad = 0;
      wq.delete();
      pulse_start();
      send(8'h00, MIN_GAP); send(8'h10, MIN_GAP);
      for (int i = 0; i < 4096; i++) begin
        send(8'(i), MIN_GAP); send(8'(i >> 8), MIN_GAP);
        send(8'h00, MIN_GAP); send(8'h00, MIN_GAP);
      end
      wait_done(50, "full");
      chk("full_nwrites", 32'(wq.size()), 4096);
      for (int j = 0; j < wq.size(); j++)
        if (wq[j].a !== 12'(j) || wq[j].d !== 32'(j) || wq[j].m !== 4'hF) bad++;
      chk("full_words_match", 32'(bad), 0);
      chk("full_err", err_o, 0);
      chk("full_core_rst", core_rst_o, 0);
    end

`ifdef ICCM_READBACK_EN
    // Readback of a corrupted word must fail the load.
    corrupt = 1'b1;
    wq.delete();
    pulse_start();
    send(8'h01, MIN_GAP); send(8'h00, MIN_GAP);
    send(8'hEF, MIN_GAP); send(8'hBE, MIN_GAP); send(8'hAD, MIN_GAP); send(8'hDE, MIN_GAP);
    wait_done(50, "rb");
    chk("rb_nwrites", 32'(wq.size()), 1);
    chk("rb_err", err_o, 1);
    chk("rb_done", done_o, 1);
    chk("rb_core_rst", core_rst_o, 1);
`endif

    chk("single_cycle_write_req", 32'(dbl), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
